// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches each 32-bit instruction as four
// little-endian byte reads and presents it to IF/ID, stalling the pipe meanwhile.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  typedef enum logic [2:0] {
    F0    = 3'd0,
    F1    = 3'd1,
    F2    = 3'd2,
    F3    = 3'd3,
    VALID = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [23:0] inst_buf_q, inst_buf_d;
  logic [31:0] inst_q, inst_d;

  logic        fetching;
  logic [1:0]  byte_idx;
  logic        unused_stall_hi;

  assign unused_stall_hi = ^stall[5:1];

  always_comb begin
    byte_idx = 2'd0;
    case (state_q)
      F1:      byte_idx = 2'd1;
      F2:      byte_idx = 2'd2;
      F3:      byte_idx = 2'd3;
      default: byte_idx = 2'd0;
    endcase
  end

  assign fetching = (state_q != VALID);

  // Gated by rst directly so the request drops the instant reset asserts.
  assign mem_req_o   = rst & fetching;
  assign stallreq_if = rst & fetching;
  assign mem_addr_o  = pc_q + {30'd0, byte_idx};
  assign if_pc       = pc_q;
  assign if_inst     = inst_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    inst_d     = inst_q;
    if (branch_flag_i) begin
      pc_d       = branch_target_i;
      state_d    = F0;
      inst_buf_d = '0;
      inst_d     = '0;
    end else begin
      case (state_q)
        F0: if (mem_ack_i) begin
          inst_buf_d[7:0] = mem_data_i;
          state_d         = F1;
        end
        F1: if (mem_ack_i) begin
          inst_buf_d[15:8] = mem_data_i;
          state_d          = F2;
        end
        F2: if (mem_ack_i) begin
          inst_buf_d[23:16] = mem_data_i;
          state_d           = F3;
        end
        F3: if (mem_ack_i) begin
          inst_d  = {mem_data_i, inst_buf_q};
          state_d = VALID;
        end
        VALID: if (!stall[0]) begin
          pc_d    = pc_q + 32'd4;
          inst_d  = '0;
          state_d = F0;
        end
        default: begin
          state_d    = F0;
          inst_buf_d = '0;
          inst_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= F0;
      pc_q       <= RESET_PC;
      inst_buf_q <= '0;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      inst_q     <= inst_d;
    end
  end

endmodule
